// File: rtl/vx_raster_merge_pkg.sv
// Shared types for the raster stamp merge block: the stamp payload and
// the per-group frame FSM states.
package vx_raster_merge_pkg;

  typedef struct packed {
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic [3:0] mask;
  } raster_stamp_t;

  localparam int STAMP_W = $bits(raster_stamp_t);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2
  } raster_merge_state_t;

endpackage

// File: rtl/vx_raster_merge_group.sv
// One output group: per-input FIFOs, arbiter, output register and the
// RUN/DRAIN/SEND frame FSM that emits a single done packet per frame.
module vx_raster_merge_group
  import vx_raster_merge_pkg::*;
#(
  parameter int GROUP_SIZE = 4,
  parameter int NUM_LANES  = 4,
  parameter int QUEUE_SIZE = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [GROUP_SIZE-1:0]                        in_valid_i,
  input  logic [GROUP_SIZE-1:0][NUM_LANES*STAMP_W-1:0] in_stamps_i,
  input  logic [GROUP_SIZE-1:0]                        in_done_i,
  output logic [GROUP_SIZE-1:0]                        in_ready_o,
  output logic                                         out_valid_o,
  output logic [NUM_LANES*STAMP_W-1:0]                 out_stamps_o,
  output logic                                         out_done_o,
  input  logic                                         out_ready_i,
  output raster_merge_state_t                          state_o,
  output logic                                         busy_o
);

  localparam int DW = NUM_LANES * STAMP_W;
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int GW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  logic [DW-1:0]                  mem_q [GROUP_SIZE][QUEUE_SIZE];
  logic [GROUP_SIZE-1:0][PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [GROUP_SIZE-1:0][CW-1:0]  count_q;
  logic [GROUP_SIZE-1:0]          sticky_q, sticky_d;
  logic [GROUP_SIZE-1:0]          nonempty, push, pop, done_hs;
  logic [GW-1:0]                  rr_q, grant;
  logic                           any_req, pop_any, send_hs;
  logic                           out_valid_q, out_done_q;
  logic [DW-1:0]                  out_data_q;
  raster_merge_state_t            state_q;

  function automatic int arb_slot(input int base, input int k);
    return (base + k) % GROUP_SIZE;
  endfunction

  // Valid/ready: a transfer happens on any edge where valid and ready are both
  // high; ready never looks at valid or data, and a producer holds its packet
  // until it is taken.
  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      nonempty[i]   = (count_q[i] != '0);
      in_ready_o[i] = (count_q[i] != CW'(QUEUE_SIZE)) && !sticky_q[i];
      push[i]       = in_valid_i[i] && in_ready_o[i] && !in_done_i[i];
      done_hs[i]    = in_valid_i[i] && in_ready_o[i] && in_done_i[i];
    end
  end

  // Scan from the highest offset down so the lowest offset from the base wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
      if (nonempty[arb_slot(FIXED_PRIO ? 0 : int'(rr_q), k)]) begin
        grant   = GW'(arb_slot(FIXED_PRIO ? 0 : int'(rr_q), k));
        any_req = 1'b1;
      end
    end
  end

  assign pop_any  = any_req && (!out_valid_q || out_ready_i);
  assign send_hs  = (state_q == SEND) && out_ready_i;
  assign sticky_d = (send_hs ? '0 : sticky_q) | done_hs;

  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      pop[i] = pop_any && (int'(grant) == i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_stamps_i[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < GROUP_SIZE; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // The done packet is loaded into the output register on DRAIN->SEND, which
  // only fires once nothing is queued, so it can never collide with a stamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      sticky_q    <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (pop_any) begin
        out_valid_q <= 1'b1;
        out_done_q  <= 1'b0;
        out_data_q  <= mem_q[grant][rd_ptr_q[grant]];
        if (!FIXED_PRIO) rr_q <= (int'(grant) == GROUP_SIZE - 1) ? '0 : grant + 1'b1;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
        out_done_q  <= 1'b0;
      end
      case (state_q)
        RUN:     if (&sticky_q) state_q <= DRAIN;
        DRAIN: begin
          if (!(|nonempty) && !out_valid_q) begin
            state_q     <= SEND;
            out_valid_q <= 1'b1;
            out_done_q  <= 1'b1;
            out_data_q  <= '0;
          end
        end
        SEND:    if (out_ready_i) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_done_o   = out_done_q;
  assign out_stamps_o = out_data_q;
  assign state_o      = state_q;
  assign busy_o       = (|nonempty) || out_valid_q || (state_q != RUN);

endmodule

// File: rtl/vx_raster_merge.sv
// Merges raster stamp producers into output groups; each group forwards its
// inputs' stamps and emits one done packet once every input has finished.
module vx_raster_merge
  import vx_raster_merge_pkg::*;
#(
  parameter int    NUM_INPUTS  = 4,
  parameter int    NUM_OUTPUTS = 1,
  parameter int    NUM_LANES   = 4,
  parameter int    QUEUE_SIZE  = 4,
  parameter string ARBITER     = "R"
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_INPUTS-1:0]                         bus_in_valid_i,
  input  logic [NUM_INPUTS-1:0][NUM_LANES*STAMP_W-1:0]  bus_in_stamps_i,
  input  logic [NUM_INPUTS-1:0]                         bus_in_done_i,
  output logic [NUM_INPUTS-1:0]                         bus_in_ready_o,
  output logic [NUM_OUTPUTS-1:0]                        bus_out_valid_o,
  output logic [NUM_OUTPUTS-1:0][NUM_LANES*STAMP_W-1:0] bus_out_stamps_o,
  output logic [NUM_OUTPUTS-1:0]                        bus_out_done_o,
  input  logic [NUM_OUTPUTS-1:0]                        bus_out_ready_i,
  output logic [NUM_OUTPUTS-1:0][1:0]                   state_o,
  output logic                                          busy
);

  localparam int GS         = NUM_INPUTS / NUM_OUTPUTS;
  localparam bit FIXED_PRIO = (ARBITER == "P");

  if (NUM_INPUTS % NUM_OUTPUTS != 0) begin : g_bad_cfg
    $error("NUM_INPUTS must be a multiple of NUM_OUTPUTS");
  end

  logic [NUM_OUTPUTS-1:0] group_busy;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_group
    vx_raster_merge_group #(
      .GROUP_SIZE (GS),
      .NUM_LANES  (NUM_LANES),
      .QUEUE_SIZE (QUEUE_SIZE),
      .FIXED_PRIO (FIXED_PRIO)
    ) u_group (
      .clk          (clk),
      .reset        (reset),
      .in_valid_i   (bus_in_valid_i[g*GS +: GS]),
      .in_stamps_i  (bus_in_stamps_i[g*GS +: GS]),
      .in_done_i    (bus_in_done_i[g*GS +: GS]),
      .in_ready_o   (bus_in_ready_o[g*GS +: GS]),
      .out_valid_o  (bus_out_valid_o[g]),
      .out_stamps_o (bus_out_stamps_o[g]),
      .out_done_o   (bus_out_done_o[g]),
      .out_ready_i  (bus_out_ready_i[g]),
      .state_o      (state_o[g]),
      .busy_o       (group_busy[g])
    );
  end

  assign busy = |group_busy;

endmodule

// File: tb/tb_vx_raster_merge.sv
// Bench for vx_raster_merge: queue-level reference model for a 4x1 round-robin
// instance, plus directed checks on a 4x2 fixed-priority instance.
module tb_vx_raster_merge;
  import vx_raster_merge_pkg::*;

  localparam int NI = 4;
  localparam int QS = 4;
  localparam int NL = 4;
  localparam int DW = NL * STAMP_W;
  typedef logic [DW-1:0] pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        in_valid, in_done, in_ready;
  logic [NI-1:0][DW-1:0] in_data;
  logic [0:0]           out_valid, out_done, out_ready;
  logic [0:0][DW-1:0]   out_data;
  logic [0:0][1:0]      state;
  logic                 busy;

  logic [NI-1:0]        b_in_valid, b_in_done, b_in_ready;
  logic [NI-1:0][DW-1:0] b_in_data;
  logic [1:0]           b_out_valid, b_out_done, b_out_ready;
  logic [1:0][DW-1:0]   b_out_data;
  logic [1:0][1:0]      b_state;
  logic                 b_busy;

  vx_raster_merge #(
    .NUM_INPUTS(4), .NUM_OUTPUTS(1), .NUM_LANES(NL), .QUEUE_SIZE(QS), .ARBITER("R")
  ) dut (
    .clk(clk), .reset(reset),
    .bus_in_valid_i(in_valid), .bus_in_stamps_i(in_data), .bus_in_done_i(in_done),
    .bus_in_ready_o(in_ready),
    .bus_out_valid_o(out_valid), .bus_out_stamps_o(out_data), .bus_out_done_o(out_done),
    .bus_out_ready_i(out_ready), .state_o(state), .busy(busy)
  );

  vx_raster_merge #(
    .NUM_INPUTS(4), .NUM_OUTPUTS(2), .NUM_LANES(NL), .QUEUE_SIZE(QS), .ARBITER("P")
  ) dut_b (
    .clk(clk), .reset(reset),
    .bus_in_valid_i(b_in_valid), .bus_in_stamps_i(b_in_data), .bus_in_done_i(b_in_done),
    .bus_in_ready_o(b_in_ready),
    .bus_out_valid_o(b_out_valid), .bus_out_stamps_o(b_out_data), .bus_out_done_o(b_out_done),
    .bus_out_ready_i(b_out_ready), .state_o(b_state), .busy(b_busy)
  );

  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: visible FIFO contents, done flags, output slot, frame phase.
  pkt_t m_q[NI][$];
  bit   m_sticky[NI];
  bit   m_valid, m_done;
  pkt_t m_data;
  int   m_phase, m_rr;

  bit   obs_done[$];
  pkt_t obs_data[$];
  int   b_tag[$];
  int   b_done_cnt;
  bit   b_out1_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_q[i].delete();
      m_sticky[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_data  = '0;
    m_phase = 0;
    m_rr    = 0;
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_valid || (m_phase != 0);
    for (int i = 0; i < NI; i++) if (m_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    bit rdy[NI];
    bit all_sticky, all_empty, old_valid;
    int g;
    all_sticky = 1'b1;
    all_empty  = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rdy[i] = (m_q[i].size() < QS) && !m_sticky[i];
      if (!m_sticky[i]) all_sticky = 1'b0;
      if (m_q[i].size() != 0) all_empty = 1'b0;
    end
    old_valid = m_valid;
    g = -1;
    if (!m_valid || out_ready[0]) begin
      for (int k = 0; k < NI; k++) begin
        if (g < 0 && m_q[(m_rr + k) % NI].size() != 0) g = (m_rr + k) % NI;
      end
    end
    if (g >= 0) begin
      m_data  = m_q[g].pop_front();
      m_valid = 1'b1;
      m_done  = 1'b0;
      m_rr    = (g + 1) % NI;
    end else if (m_valid && out_ready[0]) begin
      m_valid = 1'b0;
    end
    if (m_phase == 0 && all_sticky) m_phase = 1;
    else if (m_phase == 1 && all_empty && !old_valid) begin
      m_phase = 2;
      m_valid = 1'b1;
      m_done  = 1'b1;
      m_data  = '0;
    end else if (m_phase == 2 && out_ready[0]) begin
      m_phase = 0;
      for (int i = 0; i < NI; i++) m_sticky[i] = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      if (in_valid[i] && rdy[i]) begin
        if (in_done[i]) m_sticky[i] = 1'b1;
        else m_q[i].push_back(in_data[i]);
      end
    end
  endtask

  task automatic check_model();
    logic [NI-1:0] exp_rdy;
    for (int i = 0; i < NI; i++) exp_rdy[i] = (m_q[i].size() < QS) && !m_sticky[i];
    check("ready", 128'(in_ready), 128'(exp_rdy));
    check("out_valid", 128'(out_valid[0]), 128'(m_valid));
    if (m_valid) begin
      check("out_done", 128'(out_done[0]), 128'(m_done));
      check("out_data", 128'(out_data[0]), 128'(m_data));
    end
    check("busy", 128'(busy), 128'(model_busy()));
    check("state", 128'(state[0]), 128'(m_phase));
  endtask

  task automatic cycle();
    if (out_valid[0] && out_ready[0]) begin
      obs_done.push_back(out_done[0]);
      obs_data.push_back(out_data[0]);
    end
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic b_cycle();
    if (b_out_valid[0] && b_out_ready[0]) begin
      if (b_out_done[0]) b_done_cnt++;
      else b_tag.push_back(int'(b_out_data[0][23:16]));
    end
    if (b_out_valid[1]) b_out1_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  initial begin
    int frames, n0, n1, first1;
    in_valid = '0; in_done = '0; in_data = '0; out_ready = '0;
    b_in_valid = '0; b_in_done = '0; b_in_data = '0; b_out_ready = '0;
    b_done_cnt = 0; b_out1_seen = 1'b0;
    model_reset();

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid[0]), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_state", 128'(state[0]), 128'(RUN));
    reset = 1'b1;
    cycle();
    check("rst_ready", 128'(in_ready), 128'(4'hF));

    // All four inputs in cycle 0 -> outputs 0..3 in cycles 2..5
    out_ready = 1'b1;
    for (int i = 0; i < NI; i++) in_data[i] = pkt_t'(32'hA0 + i);
    in_valid = '1;
    cycle();
    in_valid = '0;
    check("lat_c1_valid", 128'(out_valid[0]), 128'(0));
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("order_valid", 128'(out_valid[0]), 128'(1));
      check("order_data", 128'(out_data[0]), 128'(32'hA0 + k));
    end
    cycle();
    check("order_idle", 128'(out_valid[0]), 128'(0));

    // Output stalled: five packets fill FIFO (4) plus output register (1)
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("fill_ready0", 128'(in_ready[0]), 128'(1));
      in_valid[0] = 1'b1;
      in_data[0]  = pkt_t'(32'hB0 + k);
      cycle();
    end
    in_valid = '0;
    check("full_ready0", 128'(in_ready[0]), 128'(0));
    check("full_out_data", 128'(out_data[0]), 128'(32'hB0));
    obs_done.delete(); obs_data.delete();
    out_ready = 1'b1;
    repeat (8) cycle();
    check("fill_count", 128'(obs_data.size()), 128'(5));
    for (int k = 0; k < obs_data.size() && k < 5; k++)
      check("fill_order", 128'(obs_data[k]), 128'(32'hB0 + k));

    // Done on input 2 with stamps queued: stamps first, then a single done
    out_ready = 1'b0;
    obs_done.delete(); obs_data.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = pkt_t'(32'hC0 + k);
      cycle();
    end
    in_valid = '1; in_done = '1;
    for (int i = 0; i < NI; i++) in_data[i] = pkt_t'(32'hDEAD);
    cycle();
    in_valid = '0; in_done = '0;
    cycle();
    check("drain_state", 128'(state[0]), 128'(DRAIN));
    out_ready = 1'b1;
    repeat (12) cycle();
    check("done_pkt_count", 128'(obs_done.size()), 128'(4));
    if (obs_done.size() == 4) begin
      for (int k = 0; k < 3; k++) begin
        check("done_stamp_flag", 128'(obs_done[k]), 128'(0));
        check("done_stamp_data", 128'(obs_data[k]), 128'(32'hC0 + k));
      end
      check("done_last_flag", 128'(obs_done[3]), 128'(1));
      check("done_last_data", 128'(obs_data[3]), 128'(0));
    end
    check("done_ready2", 128'(in_ready[2]), 128'(1));
    check("done_state_run", 128'(state[0]), 128'(RUN));

    // Reset asserted mid-DRAIN with the output valid
    out_ready = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1]  = pkt_t'(32'hE0);
    cycle();
    in_data[1]  = pkt_t'(32'hE1);
    cycle();
    in_valid = '1; in_done = '1;
    cycle();
    in_valid = '0; in_done = '0;
    cycle();
    check("prerst_state", 128'(state[0]), 128'(DRAIN));
    check("prerst_valid", 128'(out_valid[0]), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_state", 128'(state[0]), 128'(RUN));
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    cycle();
    check("postrst_ready", 128'(in_ready), 128'(4'hF));
    check("postrst_busy", 128'(busy), 128'(0));

    // Randomised traffic against the model
    obs_done.delete(); obs_data.delete();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (!(in_valid[i] && !in_ready[i])) begin
          in_valid[i] = ($urandom_range(0, 99) < 60);
          in_done[i]  = ($urandom_range(0, 99) < 5);
          in_data[i]  = pkt_t'({$urandom(), $urandom(), $urandom()});
        end
      end
      out_ready[0] = ($urandom_range(0, 99) < 70);
      cycle();
    end
    in_valid = '0; in_done = '0; out_ready = 1'b1;
    repeat (20) cycle();
    frames = 0;
    foreach (obs_done[k]) if (obs_done[k]) frames++;
    check("random_frames_seen", 128'(frames != 0), 128'(1));

    // Fixed priority, two groups: input 0 starves input 1 while it has data
    b_out_ready = 2'b11;
    b_tag.delete();
    for (int c = 0; c < 12; c++) begin
      b_in_valid[1:0] = 2'b11;
      b_in_data[0] = pkt_t'({8'd0, 16'(c)});
      b_in_data[1] = pkt_t'({8'd1, 16'd0});
      b_cycle();
    end
    b_in_valid = '0;
    repeat (10) b_cycle();
    n0 = 0; n1 = 0; first1 = -1;
    foreach (b_tag[k]) begin
      if (b_tag[k] == 0) n0++;
      if (b_tag[k] == 1) begin
        n1++;
        if (first1 < 0) first1 = k;
      end
    end
    check("prio_n0", 128'(n0), 128'(12));
    check("prio_n1", 128'(n1), 128'(4));
    check("prio_first1", 128'(first1), 128'(12));

    // Done on inputs 0 and 1 only: group 0 sends done, group 1 stays in RUN
    b_tag.delete(); b_done_cnt = 0; b_out1_seen = 1'b0;
    b_in_valid = 4'b0011; b_in_done = 4'b0011;
    b_cycle();
    b_in_valid = '0; b_in_done = '0;
    repeat (10) b_cycle();
    check("grp_done_cnt", 128'(b_done_cnt), 128'(1));
    check("grp_no_stamps", 128'(b_tag.size()), 128'(0));
    check("grp1_quiet", 128'(b_out1_seen), 128'(0));
    check("grp1_state", 128'(b_state[1]), 128'(RUN));
    check("grp0_state", 128'(b_state[0]), 128'(RUN));
    check("grp_ready", 128'(b_in_ready), 128'(4'hF));
    check("grp_busy", 128'(b_busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
